// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl
// Sequencing controller for an external bank of WIDTH T flip-flops.
// It reads the bank state (q_vec) and drives per-bit toggle enables (t_vec)
// so that the bank behaves as a modulo-N up/down counter. It also supports
// start, stop and clear commands. A clear zeroes the bank by toggling its
// set bits, so the bank reset is never used for that purpose.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [WIDTH-1:0] q_vec,
  output logic [WIDTH-1:0] t_vec,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tc,
  output logic             clr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    CLEAR = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             clr_done_q, clr_done_d;

  logic [WIDTH:0]   m_s;
  logic [WIDTH:0]   mmax_s;
  logic [WIDTH:0]   q_ext_s;
  logic             wrap_up_s;
  logic             wrap_dn_s;
  logic             wrap_s;
  logic [WIDTH-1:0] nxt_s;

  // Count-step arithmetic: next count value and wrap detection, in WIDTH+1 bits
  // so that a modulus of 2^WIDTH (mod_q == 0) is representable.
  always_comb begin
    m_s       = (mod_q == ZERO_W) ? {1'b1, ZERO_W} : {1'b0, mod_q};
    mmax_s    = m_s - ONE_X;
    q_ext_s   = {1'b0, q_vec};
    wrap_up_s = (q_ext_s >= mmax_s);
    wrap_dn_s = (q_vec == ZERO_W) || (q_ext_s > mmax_s);
    if (dir_q) begin
      wrap_s = wrap_up_s;
      nxt_s  = wrap_up_s ? ZERO_W : (q_vec + ONE_W);
    end else begin
      wrap_s = wrap_dn_s;
      nxt_s  = wrap_dn_s ? mmax_s[WIDTH-1:0] : (q_vec - ONE_W);
    end
  end

  // Toggle enables for the bank; held at zero while reset is asserted.
  always_comb begin
    t_vec = ZERO_W;
    if (reset) begin
      t_vec = ZERO_W;
    end else begin
      case (state_q)
        IDLE:    t_vec = ZERO_W;
        RUN:     t_vec = q_vec ^ nxt_s;
        PAUSE:   t_vec = ZERO_W;
        CLEAR:   t_vec = q_vec;
        default: t_vec = ZERO_W;
      endcase
    end
  end

  // Next-state logic with clear > stop > start priority, plus operand capture.
  always_comb begin
    state_d    = state_q;
    mod_d      = mod_q;
    dir_d      = dir_q;
    tc_d       = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
        end else if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          mod_d   = mod_val;
          dir_d   = up_dn;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The toggle applied in this cycle may wrap, whatever the command.
        tc_d = wrap_s;
        if (clear) begin
          state_d = CLEAR;
        end else if (stop) begin
          state_d = PAUSE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = CLEAR;
        end else if (stop) begin
          state_d = PAUSE;
        end else if (start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      CLEAR: begin
        // The bank is zero after this edge; go back to IDLE and flag it.
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured operands and registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mod_q      <= ZERO_W;
      dir_q      <= 1'b0;
      tc_q       <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      dir_q      <= dir_d;
      tc_q       <= tc_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q == RUN) || (state_q == PAUSE);
  assign tc       = tc_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed testbench for tff_count_ctrl with a behavioural T-ff bank model.
module tb_tff_count_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       clear;
  logic       up_dn;
  logic [3:0] mod_val;
  logic [3:0] q_vec;
  logic [3:0] t_vec;
  logic [1:0] state;
  logic       busy;
  logic       tc;
  logic       clr_done;

  int checks;
  int errors;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_dn    (up_dn),
    .mod_val  (mod_val),
    .q_vec    (q_vec),
    .t_vec    (t_vec),
    .state    (state),
    .busy     (busy),
    .tc       (tc),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External T-ff bank: shares clock and reset with the controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_vec <= 4'd0;
    else       q_vec <= q_vec ^ t_vec;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE with a zero bank (no checks).
  task automatic go_idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0b exp=00", state); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%0b exp=0", tc); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got=%0b exp=0", clr_done); end
    checks++; if (t_vec !== 4'd0) begin errors++; $display("FAIL reset_t_vec got=%0h exp=0", t_vec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL reset_q got=%0h exp=0", q_vec); end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_hold_state got=%0b exp=00", state); end
  endtask

  task automatic test_up_count();
    mod_val = 4'd10; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL up_start_state got=%0b exp=01", state); end
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL up_start_q got=%0d exp=0", q_vec); end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (q_vec !== 4'(i % 10)) begin errors++; $display("FAIL up_q step=%0d got=%0d exp=%0d", i, q_vec, i % 10); end
      checks++; if (tc !== (i == 10)) begin errors++; $display("FAIL up_tc step=%0d got=%0b exp=%0b", i, tc, (i == 10)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy step=%0d got=%0b exp=1", i, busy); end
    end
    go_idle();
  endtask

  task automatic test_down_count();
    logic [3:0] exp_q [6];
    logic       exp_tc [6];
    exp_q  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4};
    exp_tc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mod_val = 4'd5; up_dn = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL dn_start_q got=%0d exp=0", q_vec); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (q_vec !== exp_q[i]) begin errors++; $display("FAIL dn_q step=%0d got=%0d exp=%0d", i, q_vec, exp_q[i]); end
      checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL dn_tc step=%0d got=%0b exp=%0b", i, tc, exp_tc[i]); end
    end
    go_idle();
  endtask

  task automatic test_pause_resume();
    mod_val = 4'd10; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (q_vec !== 4'd5) begin errors++; $display("FAIL pr_pre_q got=%0d exp=5", q_vec); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    up_dn = 1'b0; mod_val = 4'd3;
    for (int i = 0; i < 5; i++) begin
      checks++; if (q_vec !== 4'd6) begin errors++; $display("FAIL pr_hold_q cyc=%0d got=%0d exp=6", i, q_vec); end
      checks++; if (t_vec !== 4'd0) begin errors++; $display("FAIL pr_hold_t cyc=%0d got=%0h exp=0", i, t_vec); end
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL pr_hold_state cyc=%0d got=%0b exp=10", i, state); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pr_hold_busy cyc=%0d got=%0b exp=1", i, busy); end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL pr_resume_state got=%0b exp=01", state); end
    checks++; if (q_vec !== 4'd6) begin errors++; $display("FAIL pr_resume_q got=%0d exp=6", q_vec); end
    step();
    checks++; if (q_vec !== 4'd7) begin errors++; $display("FAIL pr_next_q got=%0d exp=7", q_vec); end
    step(); step(); step();
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL pr_wrap_q got=%0d exp=0", q_vec); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL pr_wrap_tc got=%0b exp=1", tc); end
    go_idle();
  endtask

  task automatic test_clear();
    mod_val = 4'd10; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (q_vec !== 4'd7) begin errors++; $display("FAIL clr_pre_q got=%0d exp=7", q_vec); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (q_vec !== 4'd8) begin errors++; $display("FAIL clr_q8 got=%0d exp=8", q_vec); end
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL clr_state got=%0b exp=11", state); end
    checks++; if (t_vec !== 4'b1000) begin errors++; $display("FAIL clr_t_vec got=%0b exp=1000", t_vec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%0b exp=0", busy); end
    step();
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL clr_done_q got=%0d exp=0", q_vec); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_done_state got=%0b exp=00", state); end
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL clr_done_pulse got=%0b exp=1", clr_done); end
    step();
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_end got=%0b exp=0", clr_done); end
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++; if (q_vec !== 4'd3) begin errors++; $display("FAIL clrst_pre_q got=%0d exp=3", q_vec); end
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL clrst_state got=%0b exp=11", state); end
    checks++; if (t_vec !== 4'b0100) begin errors++; $display("FAIL clrst_t_vec got=%0b exp=0100", t_vec); end
    step();
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL clrst_q got=%0d exp=0", q_vec); end
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL clrst_done got=%0b exp=1", clr_done); end
  endtask

  task automatic test_full_range();
    mod_val = 4'd0; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    checks++; if (q_vec !== 4'd15) begin errors++; $display("FAIL full_q15 got=%0d exp=15", q_vec); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL full_tc15 got=%0b exp=0", tc); end
    step();
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL full_wrap_q got=%0d exp=0", q_vec); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL full_wrap_tc got=%0b exp=1", tc); end
    go_idle();
    mod_val = 4'd1; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL mod1_start_tc got=%0b exp=0", tc); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL mod1_q cyc=%0d got=%0d exp=0", i, q_vec); end
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL mod1_tc cyc=%0d got=%0b exp=1", i, tc); end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_run();
    mod_val = 4'd10; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (q_vec !== 4'd5) begin errors++; $display("FAIL rst_pre_q got=%0d exp=5", q_vec); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_mid_state got=%0b exp=00", state); end
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL rst_mid_q got=%0d exp=0", q_vec); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_mid_tc got=%0b exp=0", tc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if (t_vec !== 4'd0) begin errors++; $display("FAIL rst_mid_t got=%0h exp=0", t_vec); end
    #2;
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (q_vec !== 4'd0) begin errors++; $display("FAIL rst_restart_q0 got=%0d exp=0", q_vec); end
    step();
    checks++; if (q_vec !== 4'd1) begin errors++; $display("FAIL rst_restart_q1 got=%0d exp=1", q_vec); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    up_dn = 1'b0; mod_val = 4'd0;
    test_reset();
    test_up_count();
    test_down_count();
    test_pause_resume();
    test_clear();
    test_full_range();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
